// File: rtl/aqfp_sfq_lane_arbiter_if.sv
// Handshake/bus bundle between SFQ-side requesters and the lane arbiter.
// master: requester side (drives req/din). slave: arbiter side.
interface aqfp_sfq_lane_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned PHASES = 4
);
  localparam int unsigned PW = (PHASES > 1) ? $clog2(PHASES) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic [NREQ-1:0] gnt;
  logic            lane_data;
  logic            lane_valid;
  logic [PW-1:0]   phase;
  logic            busy;
  logic            tc_err;

  modport master (
    output req, din,
    input  gnt, lane_data, lane_valid, phase, busy, tc_err
  );

  modport slave (
    input  req, din,
    output gnt, lane_data, lane_valid, phase, busy, tc_err
  );
endinterface

// File: rtl/aqfp_sfq_lane_arbiter.sv
// Round-robin arbiter sharing one SFQ-to-AQFP conversion lane among NREQ requesters.
// A free-running phase counter tracks the AQFP excitation frame; a grant is decided
// one cycle before SAMPLE_PH so lane_data/lane_valid/gnt are registered and valid
// exactly in the sample cycle, then lane_data is held for HOLD more cycles.
// Optional feature: define AQFP_SFQ_TCHECK_EN to enable the sticky tc_err check that
// flags the winner's din changing while its bit is still on the lane.
module aqfp_sfq_lane_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned PHASES    = 4,
  parameter int unsigned SAMPLE_PH = 2,
  parameter int unsigned HOLD      = 1
) (
  input  logic                        SFQclkin,
  input  logic                        rst_n,
  aqfp_sfq_lane_arbiter_if.slave      bus
);

  localparam int unsigned PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // HOLD <= PHASES-2, so a phase-wide counter always fits.
  localparam int unsigned HW = PW;

  typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            lane_data_q, lane_data_d;
  logic            lane_valid_q, lane_valid_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic [IW-1:0]   winner;
  logic            found;
  logic            decide;
  int unsigned     idx;

  // Round-robin search: first set req at or after rr_q, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Decision edge: idle, one phase before the AQFP sample phase, someone asking.
  assign decide = (state_q == StIdle) && (phase_q == PW'(SAMPLE_PH - 1)) && found;

  // Phase counter free-runs regardless of FSM state.
  always_comb begin
    phase_d = (phase_q == PW'(PHASES - 1)) ? '0 : phase_q + 1'b1;
  end

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    lane_data_d  = lane_data_q;
    lane_valid_d = lane_valid_q;
    rr_d         = rr_q;
    hold_cnt_d   = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        lane_data_d = 1'b0;
        if (decide) begin
          state_d      = StDrive;
          gnt_d        = NREQ'(1) << winner;
          lane_data_d  = bus.din[winner];
          lane_valid_d = 1'b1;
          rr_d         = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
      end
      StDrive: begin
        gnt_d        = '0;
        lane_valid_d = 1'b0;
        if (HOLD > 0) begin
          state_d    = StHold;
          hold_cnt_d = HW'((HOLD > 0) ? HOLD - 1 : 0);
        end else begin
          state_d     = StIdle;
          lane_data_d = 1'b0;
        end
      end
      StHold: begin
        if (hold_cnt_q == '0) begin
          state_d     = StIdle;
          lane_data_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d      = StIdle;
        gnt_d        = '0;
        lane_data_d  = 1'b0;
        lane_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge SFQclkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      rr_q         <= '0;
      gnt_q        <= '0;
      lane_data_q  <= 1'b0;
      lane_valid_q <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      lane_data_q  <= lane_data_d;
      lane_valid_q <= lane_valid_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

`ifdef AQFP_SFQ_TCHECK_EN
  logic [IW-1:0] win_q, win_d;
  logic          tc_err_q, tc_err_d;

  // Remember the winner and flag its din moving while its bit is on the lane.
  always_comb begin
    win_d    = decide ? winner : win_q;
    tc_err_d = tc_err_q;
    if ((state_q != StIdle) && (bus.din[win_q] != lane_data_q)) tc_err_d = 1'b1;
  end

  // Sticky error and winner index registers.
  always_ff @(posedge SFQclkin or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      tc_err_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      tc_err_q <= tc_err_d;
    end
  end

  assign bus.tc_err = tc_err_q;
`else
  assign bus.tc_err = 1'b0;
`endif

  assign bus.gnt        = gnt_q;
  assign bus.lane_data  = lane_data_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.phase      = phase_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_aqfp_sfq_lane_arbiter.sv
// Bench for aqfp_sfq_lane_arbiter: directed scenarios then random traffic, all
// compared against a timeline model (grant cycle, held value, round-robin pointer).
module tb_aqfp_sfq_lane_arbiter;
  localparam int unsigned NREQ      = 4;
  localparam int unsigned PHASES    = 4;
  localparam int unsigned SAMPLE_PH = 2;
  localparam int unsigned HOLD      = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  aqfp_sfq_lane_arbiter_if #(.NREQ(NREQ), .PHASES(PHASES)) bus ();

  aqfp_sfq_lane_arbiter #(
    .NREQ(NREQ), .PHASES(PHASES), .SAMPLE_PH(SAMPLE_PH), .HOLD(HOLD)
  ) dut (
    .SFQclkin(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: n = edges since reset release; a grant occupies cycles g_cyc..g_cyc+HOLD.
  int n, rr, g_cyc, g_idx, g_val, err;

  task automatic model_reset();
    n = 0; rr = 0; g_cyc = -100; g_idx = 0; g_val = 0; err = 0;
  endtask

  function automatic bit m_busy(int c);
    return (c >= g_cyc) && (c <= g_cyc + int'(HOLD));
  endfunction

  task automatic model_edge();
    bit bprev;
    bit fnd;
    int j;
    int w;
    bprev = m_busy(n);
    fnd = 0;
    w = 0;
`ifdef AQFP_SFQ_TCHECK_EN
    if (bprev && (bus.din[g_idx] != g_val[0])) err = 1;
`endif
    if (!bprev && ((n % PHASES) == SAMPLE_PH - 1) && (|bus.req)) begin
      for (int i = 0; i < NREQ; i++) begin
        j = (rr + i) % NREQ;
        if (!fnd && bus.req[j]) begin fnd = 1; w = j; end
      end
      g_cyc = n + 1;
      g_idx = w;
      g_val = int'(bus.din[w]);
      rr = (w + 1) % NREQ;
    end
    n = n + 1;
  endtask

  task automatic chk(string tag, string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk(tag, "phase", 32'(bus.phase), n % PHASES);
    chk(tag, "gnt", 32'(bus.gnt), (n == g_cyc) ? (32'd1 << g_idx) : 32'd0);
    chk(tag, "lane_valid", 32'(bus.lane_valid), (n == g_cyc) ? 32'd1 : 32'd0);
    chk(tag, "lane_data", 32'(bus.lane_data), m_busy(n) ? g_val : 32'd0);
    chk(tag, "busy", 32'(bus.busy), m_busy(n) ? 32'd1 : 32'd0);
    chk(tag, "tc_err", 32'(bus.tc_err), err);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after an edge; releases well before the next edge.
  task automatic do_reset(string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    chk(tag, "rst_lane", 32'(bus.lane_data), 32'd0);
    chk(tag, "rst_busy", 32'(bus.busy), 32'd0);
    chk(tag, "rst_phase", 32'(bus.phase), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] seq [5];

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0001;
    bus.req = '0;
    bus.din = '0;
    model_reset();
    #7;
    check_all("reset");
    #2;
    rst_n = 1'b1;

    // Idle frames: phase free-runs, first edge lands on phase 1.
    for (int k = 0; k < 8; k++) begin
      step("idle");
      chk("idle", "phase_seq", 32'(bus.phase), (k + 1) % PHASES);
    end

    // Single request from phase 0.
    bus.req = 4'b0001; bus.din = 4'b0001;
    step("single");
    step("single");
    chk("single", "gnt_p2", 32'(bus.gnt), 32'b0001);
    chk("single", "valid_p2", 32'(bus.lane_valid), 32'd1);
    chk("single", "data_p2", 32'(bus.lane_data), 32'd1);
    bus.req = '0;
    step("single");
    chk("single", "data_p3", 32'(bus.lane_data), 32'd1);
    chk("single", "valid_p3", 32'(bus.lane_valid), 32'd0);
    step("single");
    chk("single", "data_p0", 32'(bus.lane_data), 32'd0);
    chk("single", "busy_p0", 32'(bus.busy), 32'd0);

    // All four requesting for five frames: rotating grants.
    do_reset("rst_rr");
    bus.req = 4'b1111; bus.din = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      step("rr");
      if ((k % 4) == 1) chk("rr", "gnt_seq", 32'(bus.gnt), 32'(seq[k / 4]));
    end
    bus.req = '0;

    // Late request raised at phase 2 waits a full frame.
    step("late");
    step("late");
    bus.req = 4'b0100; bus.din = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      step("late");
      chk("late", "gnt", 32'(bus.gnt), (k == 3) ? 32'b0100 : 32'd0);
    end
    bus.req = '0;

    // Reset during HOLD with a pending request on requester 1.
    do_reset("rst_hold_pre");
    bus.req = 4'b0001; bus.din = 4'b0011;
    step("hold");
    step("hold");
    step("hold");
    chk("hold", "in_hold_data", 32'(bus.lane_data), 32'd1);
    chk("hold", "in_hold_busy", 32'(bus.busy), 32'd1);
    bus.req = 4'b0010;
    do_reset("rst_mid_hold");
    step("after_rst");
    step("after_rst");
    chk("after_rst", "gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;

    // Winner's din drops during HOLD.
    step("tc");
    do_reset("rst_tc");
    bus.req = 4'b0001; bus.din = 4'b0001;
    step("tc");
    step("tc");
    bus.req = '0;
    step("tc");
    bus.din = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step("tc");
`ifdef AQFP_SFQ_TCHECK_EN
      chk("tc", "tc_err_set", 32'(bus.tc_err), 32'd1);
`else
      chk("tc", "tc_err_off", 32'(bus.tc_err), 32'd0);
`endif
    end
    do_reset("rst_tc_clr");
    chk("tc", "tc_err_clr", 32'(bus.tc_err), 32'd0);

    // Random traffic: requests held until granted, din toggling freely.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && ($urandom_range(3) == 0)) bus.req[i] = 1'b1;
      bus.din = NREQ'($urandom);
      step("rand");
      if ((g_cyc == n) && ($urandom_range(1) == 0)) bus.req[g_idx] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
